// File: rtl/ps2_rx_if.sv
// ps2_rx_if: PS/2 pin pair plus the decoded key-event outputs of ps2_rx.
// master = keyboard/host-side model driving the pins and consuming events,
// slave  = the ps2_rx receiver.
interface ps2_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       is_break;
   logic       is_extended;
   logic       frame_err;

   modport master (
      output ps2_clk,
      output ps2_data,
      input  scan_code,
      input  scan_valid,
      input  is_break,
      input  is_extended,
      input  frame_err
   );

   modport slave (
      input  ps2_clk,
      input  ps2_data,
      output scan_code,
      output scan_valid,
      output is_break,
      output is_extended,
      output frame_err
   );
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard receiver. Synchronises and deglitches the raw pins,
// deserialises 11-bit device-to-host frames, strips E0/F0 prefixes and emits
// one tagged set-2 scan code per key event.
// Optional feature macro: PS2_PARITY_CHECK_EN (defined -> parity errors drop
// the byte and pulse frame_err; undefined -> parity bit is ignored).
module ps2_rx #(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input logic     clk,
   input logic     reset,
   ps2_rx_if.slave ps2
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic                   clk_s;
   logic                   data_s;

   logic [FW-1:0] fcnt_q;
   logic          filt_q;
   logic          filt_dly_q;
   logic          fall_q;

   logic [1:0]    state_q,   state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q,   shift_d;
   logic          par_q,     par_d;
   logic [TW-1:0] to_cnt_q,  to_cnt_d;
   logic          ext_q,     ext_d;
   logic          brk_q,     brk_d;
   logic [7:0]    code_q,    code_d;
   logic          is_ext_q,  is_ext_d;
   logic          is_brk_q,  is_brk_d;
   logic          valid_q,   valid_d;
   logic          err_q,     err_d;

   logic          par_calc;
   logic          par_ok;

   assign clk_s  = clk_sync_q[SYNC_STAGES-1];
   assign data_s = data_sync_q[SYNC_STAGES-1];

   // Odd parity: data bits XOR parity bit must be 1.
   assign par_calc = ^{shift_q, par_q};
`ifdef PS2_PARITY_CHECK_EN
   assign par_ok = par_calc;
`else
   assign par_ok = par_calc | 1'b1;
`endif

   // Pin synchronisers (idle level of both PS/2 lines is high).
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2.ps2_clk};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2.ps2_data};
      end
   end

   // Clock deglitch filter and registered falling-edge pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         fcnt_q     <= '0;
         filt_q     <= 1'b1;
         filt_dly_q <= 1'b1;
         fall_q     <= 1'b0;
      end else begin
         if (clk_s != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
               filt_q <= clk_s;
               fcnt_q <= '0;
            end else begin
               fcnt_q <= fcnt_q + 1'b1;
            end
         end else begin
            fcnt_q <= '0;
         end
         filt_dly_q <= filt_q;
         fall_q     <= filt_dly_q & ~filt_q;
      end
   end

   // Frame FSM, prefix tracking, timeout and output next-state logic.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      to_cnt_d  = to_cnt_q;
      ext_d     = ext_q;
      brk_d     = brk_q;
      code_d    = code_q;
      is_ext_d  = is_ext_q;
      is_brk_d  = is_brk_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;

      if (state_q != S_IDLE) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end

      if (fall_q) begin
         to_cnt_d = '0;
         case (state_q)
            S_IDLE: begin
               // A high start bit is a false start and is silently ignored.
               if (!data_s) begin
                  state_d   = S_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            S_DATA: begin
               shift_d   = {data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = S_PARITY;
               end
            end
            S_PARITY: begin
               par_d   = data_s;
               state_d = S_STOP;
            end
            default: begin
               state_d = S_IDLE;
               if (data_s && par_ok) begin
                  case (shift_q)
                     8'hE0: ext_d = 1'b1;
                     8'hF0: brk_d = 1'b1;
                     default: begin
                        code_d   = shift_q;
                        is_ext_d = ext_q;
                        is_brk_d = brk_q;
                        valid_d  = 1'b1;
                        ext_d    = 1'b0;
                        brk_d    = 1'b0;
                     end
                  endcase
               end else begin
                  err_d = 1'b1;
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
            end
         endcase
      end else if ((state_q != S_IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES))) begin
         // Device stopped clocking mid-frame: abandon it and any pending prefix.
         state_d  = S_IDLE;
         to_cnt_d = '0;
         err_d    = 1'b1;
         ext_d    = 1'b0;
         brk_d    = 1'b0;
      end
   end

   // Control and output state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= 3'd0;
         to_cnt_q  <= '0;
         ext_q     <= 1'b0;
         brk_q     <= 1'b0;
         code_q    <= 8'h00;
         is_ext_q  <= 1'b0;
         is_brk_q  <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         to_cnt_q  <= to_cnt_d;
         ext_q     <= ext_d;
         brk_q     <= brk_d;
         code_q    <= code_d;
         is_ext_q  <= is_ext_d;
         is_brk_q  <= is_brk_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   // Frame datapath registers; contents are only meaningful mid-frame.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      par_q   <= par_d;
   end

   assign ps2.scan_code   = code_q;
   assign ps2.scan_valid  = valid_q;
   assign ps2.is_break    = is_brk_q;
   assign ps2.is_extended = is_ext_q;
   assign ps2.frame_err   = err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: scoreboard bench for ps2_rx (SYNC_STAGES=2, FILTER_LEN=2,
// TIMEOUT_CYCLES=200). Expected events are queued as frames are driven and
// popped when the receiver reports scan_valid or frame_err.
module tb_ps2_rx;

   localparam int HALF    = 20;
   localparam int GAP     = 40;
   localparam int LATENCY = 6;

   typedef struct {
      logic [7:0] code;
      logic       brk;
      logic       ext;
      logic       err;
      logic       lat;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   t_stop;
   int   n_tests;
   int   n_fail;
   exp_t sbq[$];

   ps2_rx_if bus ();

   ps2_rx #(
      .SYNC_STAGES    (2),
      .FILTER_LEN     (2),
      .TIMEOUT_CYCLES (200)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .ps2   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] code, input logic brk, input logic ext,
                       input logic err, input logic lat);
      exp_t e;
      e.code = code; e.brk = brk; e.ext = ext; e.err = err; e.lat = lat;
      sbq.push_back(e);
   endtask

   // Drive nbits of a frame (start, 8 data LSB first, odd parity, stop).
   task automatic send_frame(input logic [7:0] d, input logic bad_par,
                             input int nbits, input logic glitch);
      logic [10:0] f;
      f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_data = f[i];
         if (glitch) begin
            repeat (HALF/2) @(posedge clk);
            #1 bus.ps2_clk = 1'b0;
            @(posedge clk);
            #1 bus.ps2_clk = 1'b1;
            repeat (HALF/2) @(posedge clk);
         end else begin
            repeat (HALF) @(posedge clk);
         end
         #1 bus.ps2_clk = 1'b0;
         if (i == 10) t_stop = cyc;
         repeat (HALF) @(posedge clk);
         #1 bus.ps2_clk = 1'b1;
      end
      bus.ps2_data = 1'b1;
      repeat (GAP) @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && (bus.scan_valid || bus.frame_err)) begin
         check("exclusive", int'(bus.scan_valid & bus.frame_err), 0);
         if (sbq.size() == 0) begin
            check("unexpected_event", 1, 0);
         end else begin
            e = sbq.pop_front();
            check("event_kind_err", int'(bus.frame_err), int'(e.err));
            if (bus.scan_valid) begin
               check("scan_code", int'(bus.scan_code), int'(e.code));
               check("is_break", int'(bus.is_break), int'(e.brk));
               check("is_extended", int'(bus.is_extended), int'(e.ext));
            end
            if (e.lat) check("latency", cyc - t_stop, LATENCY);
         end
      end
   end

   initial begin
      cyc = 0; t_stop = 0; n_tests = 0; n_fail = 0;
      reset = 1'b1;
      bus.ps2_clk = 1'b1;
      bus.ps2_data = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_scan_code", int'(bus.scan_code), 0);
      check("rst_scan_valid", int'(bus.scan_valid), 0);
      check("rst_is_break", int'(bus.is_break), 0);
      check("rst_is_extended", int'(bus.is_extended), 0);
      check("rst_frame_err", int'(bus.frame_err), 0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (10) @(posedge clk); #1;

      // Plain make code with latency.
      push(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'h1C, 1'b0, 11, 1'b0);

      // Break code, then the flag must be gone.
      push(8'h1C, 1'b1, 1'b0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 11, 1'b0);
      send_frame(8'h1C, 1'b0, 11, 1'b0);
      push(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'h1C, 1'b0, 11, 1'b0);

      // Extended break.
      push(8'h75, 1'b1, 1'b1, 1'b0, 1'b1);
      send_frame(8'hE0, 1'b0, 11, 1'b0);
      send_frame(8'hF0, 1'b0, 11, 1'b0);
      send_frame(8'h75, 1'b0, 11, 1'b0);

      // Bad parity.
`ifdef PS2_PARITY_CHECK_EN
      push(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
`else
      push(8'h32, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
      send_frame(8'h32, 1'b1, 11, 1'b0);
      push(8'h21, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'h21, 1'b0, 11, 1'b0);

      // Bad stop bit: start + 8 data + parity, then stop driven low.
      push(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      send_frame(8'h44, 1'b0, 10, 1'b0);
      bus.ps2_data = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 bus.ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 bus.ps2_clk = 1'b1;
      bus.ps2_data = 1'b1;
      repeat (GAP) @(posedge clk); #1;

      // Timeout after a break prefix: flag must be cleared.
      send_frame(8'hF0, 1'b0, 11, 1'b0);
      push(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      send_frame(8'h55, 1'b0, 5, 1'b0);
      repeat (250) @(posedge clk); #1;
      check("timeout_reported", sbq.size(), 0);
      push(8'h24, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'h24, 1'b0, 11, 1'b0);

      // Reset mid-frame: no error, outputs cleared, next frame fine.
      send_frame(8'h66, 1'b0, 4, 1'b0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("midrst_scan_code", int'(bus.scan_code), 0);
      check("midrst_is_break", int'(bus.is_break), 0);
      check("midrst_is_extended", int'(bus.is_extended), 0);
      check("midrst_frame_err", int'(bus.frame_err), 0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (20) @(posedge clk); #1;
      push(8'h24, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'h24, 1'b0, 11, 1'b0);

      // One-cycle clock glitches between bits.
      push(8'h2D, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'h2D, 1'b0, 11, 1'b1);

      repeat (300) @(posedge clk);
      @(negedge clk);
      check("scoreboard_empty", sbq.size(), 0);
      check("idle_scan_valid", int'(bus.scan_valid), 0);
      check("held_scan_code", int'(bus.scan_code), 8'h2D);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
